// File: rtl/action_phv_merger_if.sv
// Bundles the PHV issue, ALU result and merged-PHV output signals of the action-stage merger.
// The slave modport is the merger's side; the master modport is the surrounding stage.
interface action_phv_merger_if #(
  parameter int NUM_ALU    = 8,
  parameter int DATA_WIDTH = 32,
  parameter int META_WIDTH = 256,
  parameter int PHV_W      = NUM_ALU*DATA_WIDTH + META_WIDTH
);
  logic [PHV_W-1:0]              phv_in;
  logic [NUM_ALU-1:0]            lane_en_in;
  logic                          phv_in_valid;
  logic                          phv_in_ready;
  logic [NUM_ALU*DATA_WIDTH-1:0] container_in;
  logic [NUM_ALU-1:0]            container_valid_in;
  logic [NUM_ALU-1:0]            alu_ready_out;
  logic [PHV_W-1:0]              phv_out;
  logic                          phv_out_valid;
  logic                          phv_out_ready;
  logic                          dup_err;

  modport master (
    output phv_in, lane_en_in, phv_in_valid, container_in, container_valid_in, phv_out_ready,
    input  phv_in_ready, alu_ready_out, phv_out, phv_out_valid, dup_err
  );

  modport slave (
    input  phv_in, lane_en_in, phv_in_valid, container_in, container_valid_in, phv_out_ready,
    output phv_in_ready, alu_ready_out, phv_out, phv_out_valid, dup_err
  );
endinterface

// File: rtl/action_phv_merger.sv
// Rebuilds a PHV from the issued copy plus one result container per enabled ALU lane.
// All outputs registered; ALUs are held off (alu_ready_out=0) while a merged PHV waits downstream.
module action_phv_merger #(
  parameter int NUM_ALU    = 8,
  parameter int DATA_WIDTH = 32,
  parameter int META_WIDTH = 256,
  parameter int PHV_W      = NUM_ALU*DATA_WIDTH + META_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  action_phv_merger_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_e;

  state_e             state_q, state_d;
  logic [NUM_ALU-1:0] en_q, en_d;
  logic [NUM_ALU-1:0] coll_q, coll_d;
  logic [PHV_W-1:0]   phv_q, phv_d;
  logic               vld_q, vld_d;
  logic               in_rdy_q, in_rdy_d;
  logic [NUM_ALU-1:0] alu_rdy_q, alu_rdy_d;
  logic               err_q, err_d;
  logic [NUM_ALU-1:0] hit;

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    coll_d    = coll_q;
    phv_d     = phv_q;
    vld_d     = vld_q;
    in_rdy_d  = in_rdy_q;
    alu_rdy_d = alu_rdy_q;
    err_d     = err_q;
    hit       = '0;

    case (state_q)
      IDLE: begin
        if (|bus.container_valid_in) err_d = 1'b1;
        if (bus.phv_in_valid) begin
          phv_d    = bus.phv_in;
          en_d     = bus.lane_en_in;
          coll_d   = '0;
          in_rdy_d = 1'b0;
          if (bus.lane_en_in == '0) begin
            state_d   = OUTPUT;
            alu_rdy_d = '0;
          end else begin
            state_d   = COLLECT;
            alu_rdy_d = bus.lane_en_in;
          end
        end
      end

      COLLECT: begin
        hit = bus.container_valid_in & en_q & ~coll_q;
        if ((bus.container_valid_in & ~hit) != '0) err_d = 1'b1;
        for (int i = 0; i < NUM_ALU; i++) begin
          if (hit[i]) phv_d[PHV_W-1-i*DATA_WIDTH -: DATA_WIDTH] = bus.container_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
        coll_d = coll_q | hit;
        // Completion raises valid on the same edge as the last capture.
        if (coll_d == en_q) begin
          state_d   = OUTPUT;
          vld_d     = 1'b1;
          alu_rdy_d = '0;
        end else begin
          alu_rdy_d = en_q & ~coll_d;
        end
      end

      OUTPUT: begin
        if (|bus.container_valid_in) err_d = 1'b1;
        // An all-disabled PHV enters here with valid still low and raises it one cycle later.
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (bus.phv_out_ready) begin
          vld_d    = 1'b0;
          in_rdy_d = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_q      <= '0;
      coll_q    <= '0;
      phv_q     <= '0;
      vld_q     <= 1'b0;
      in_rdy_q  <= 1'b1;
      alu_rdy_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      coll_q    <= coll_d;
      phv_q     <= phv_d;
      vld_q     <= vld_d;
      in_rdy_q  <= in_rdy_d;
      alu_rdy_q <= alu_rdy_d;
      err_q     <= err_d;
    end
  end

  assign bus.phv_out       = phv_q;
  assign bus.phv_out_valid = vld_q;
  assign bus.phv_in_ready  = in_rdy_q;
  assign bus.alu_ready_out = alu_rdy_q;
  assign bus.dup_err       = err_q;

endmodule

// File: doc/action_phv_merger.md
Name: action_phv_merger

Overview:
- Sits directly downstream of the per-container ALUs in an RMT action stage.
- Latches the incoming PHV when actions are issued, then collects one result container from each enabled ALU lane. Each ALU's result is a single-cycle valid pulse with combinational data.
- Once all enabled lanes have reported, it presents the rebuilt PHV to the next stage with valid/ready.
- Drives per-lane ready back to the ALUs so they stall while an output PHV is pending.

Parameters:
- NUM_ALU, 8, number of ALU lanes/containers.
- DATA_WIDTH, 32, container width in bits.
- META_WIDTH, 256, width of the PHV metadata tail, passed through unchanged.
- PHV_W, NUM_ALU*DATA_WIDTH+META_WIDTH, full PHV width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- phv_in  in  PHV_W  PHV from the issue stage. Lane i occupies [PHV_W-1-i*DATA_WIDTH -: DATA_WIDTH]; metadata occupies [META_WIDTH-1:0].
- lane_en_in  in  NUM_ALU  bit i = 1: lane i result comes from ALU i; 0: keep the phv_in container.
- phv_in_valid  in  1  phv_in/lane_en_in valid.
- phv_in_ready  out  1  merger can accept a new PHV.
- container_in  in  NUM_ALU*DATA_WIDTH  ALU results; lane i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- container_valid_in  in  NUM_ALU  one-cycle result pulse per lane.
- alu_ready_out  out  NUM_ALU  per-lane ready to the ALU's ready_in.
- phv_out  out  PHV_W  merged PHV.
- phv_out_valid  out  1  phv_out valid.
- phv_out_ready  in  1  downstream accept.
- dup_err  out  1  sticky protocol-error flag.

Behaviour:
- All outputs are registered.
- Reset values: phv_in_ready=1; alu_ready_out=0; phv_out=0; phv_out_valid=0; dup_err=0; state=IDLE; collected mask=0.
- Reset mid-operation discards any partial PHV and returns to IDLE next cycle. ALU pulses arriving during reset are ignored.
- States: IDLE, COLLECT, OUTPUT.
- IDLE:
  - phv_in_ready=1, alu_ready_out=0.
  - On phv_in_valid: latch phv_in into the output buffer, latch lane_en_in into the enable mask, clear the collected mask, drop phv_in_ready next cycle.
  - If lane_en_in==0, go to OUTPUT (phv_out_valid=1 the following cycle); otherwise go to COLLECT.
- COLLECT:
  - alu_ready_out[i] = en[i] & ~collected[i].
  - On container_valid_in[i] with en[i]&~collected[i]: write container_in lane i into buffer lane i and set collected[i].
  - Any number of lanes may arrive in the same cycle; all are captured.
  - When (collected | newly captured) == en: go to OUTPUT; phv_out_valid=1 the cycle after the last capture; all alu_ready_out drop the same cycle.
- OUTPUT:
  - phv_out and phv_out_valid are held stable until phv_out_ready.
  - On phv_out_valid & phv_out_ready: phv_out_valid=0 and phv_in_ready=1 next cycle; return to IDLE.
  - If phv_out_ready is already high when valid rises, the transfer happens in that cycle.
- Protocol errors:
  - A container_valid_in[i] pulse while in IDLE or OUTPUT, on a disabled lane, or on an already-collected lane is ignored; buffer data is unchanged and dup_err is set.
  - dup_err clears only on reset.
- Bit layout:
  - Disabled lanes and the metadata tail come out bit-identical to phv_in.
  - No arithmetic; pure lane replacement.
- Throughput: at most one PHV per (collect latency + 2) cycles. No input buffering beyond the single PHV.

Test Plan:
- All lanes arrive together:
  - Stimulus: lane_en=8'hFF, PHV containers all 0, metadata=256'hA5...; next cycle all 8 container_valid_in pulse with lane i=32'h100+i, phv_out_ready=1.
  - Response: phv_out_valid one cycle later; lane i=32'h100+i; metadata unchanged; phv_in_ready=1 the following cycle.
- Staggered arrival:
  - Stimulus: lane_en=8'h05, lane0 result 32'd7 at t+1, lane2 result 32'd9 at t+4.
  - Response: alu_ready_out=8'h05 then 8'h04 then 0; output valid at t+5 with lane0=7, lane2=9, other lanes = phv_in values.
- No enabled lanes:
  - Stimulus: lane_en=0.
  - Response: phv_out == phv_in with phv_out_valid two cycles after phv_in_valid; alu_ready_out stays 0.
- Backpressure:
  - Stimulus: phv_out_ready=0 for 10 cycles after valid; a new phv_in_valid offered during the stall.
  - Response: phv_out stable, phv_in_ready=0, alu_ready_out=0, new PHV not accepted until one cycle after the handshake.
- Duplicate and stray pulses:
  - Stimulus: lane1 pulses twice (32'd3 then 32'd4) with lane_en=8'h03; lane5 pulses while disabled.
  - Response: lane1 out=3, lane5 = phv_in value, dup_err=1 and stays 1 across subsequent PHVs.
- Reset mid-collect:
  - Stimulus: rst_n low for 1 cycle after lane0 of lane_en=8'h03 has been collected.
  - Response: all outputs return to reset values, no phv_out_valid; the next PHV is merged correctly with no stale lane0 data.
